// File: rtl/div3_rr_sched_if.sv
// div3_rr_sched_if: request/response bundle between requesters and the shared div-3 engine
interface div3_rr_sched_if #(parameter int NREQ = 4, parameter int WORDW = 64);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*WORDW-1:0] req_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic rsp_div;
  logic [1:0] rsp_residue;
  modport master (
    output req_valid, req_data, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_div, rsp_residue
  );
  modport slave (
    input req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_div, rsp_residue
  );
endinterface

// File: rtl/div3_rr_sched.sv
// div3_rr_sched: round-robin arbiter feeding one chunk-serial mod-3 engine
module div3_rr_sched #(
  parameter int NREQ = 4,
  parameter int WORDW = 64,
  parameter int CHUNKW = 16
) (
  input logic clk,
  input logic rst,
  div3_rr_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int NCHUNK = WORDW / CHUNKW;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, win, id;
  logic found, last;
  logic [WORDW-1:0] word, sel;
  logic [CW-1:0] idx;
  logic [1:0] acc, acc_n, cres;
  logic [2:0] sum3;
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++)
      if (!found && bus.req_valid[IDW'((int'(ptr) + i) % NREQ)]) begin
        found = 1'b1;
        win = IDW'((int'(ptr) + i) % NREQ);
      end
  end
  // constant-index mux keeps unselected (possibly X) words off the datapath
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (win == IDW'(i)) sel = bus.req_data[i*WORDW +: WORDW];
  end
  // even bits weigh +1, odd bits weigh -1 == +2 (mod 3), so the sum never goes negative
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < CHUNKW; i++)
      s = s + (word[i] ? ((i % 2) != 0 ? 2 : 1) : 0);
    cres = 2'(s % 3);
  end
  assign sum3 = {1'b0, acc} + {1'b0, cres};
  assign acc_n = sum3 >= 3'd3 ? 2'(sum3 - 3'd3) : sum3[1:0];
  assign last = idx == CW'(NCHUNK - 1);
  assign bus.req_ready = (state == IDLE && found && !rst) ? NREQ'(1) << win : '0;
  assign bus.rsp_valid = state == RESP;
  always_comb begin
    state_n = state == IDLE ? (found ? RUN : IDLE)
            : state == RUN  ? (last ? RESP : RUN)
            : (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= IDW'(NREQ - 1);
      id <= '0;
      word <= '0;
      idx <= '0;
      acc <= '0;
      bus.rsp_id <= '0;
      bus.rsp_div <= 1'b0;
      bus.rsp_residue <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        word <= sel;
        id <= win;
        ptr <= win;
        acc <= '0;
        idx <= '0;
      end
      if (state == RUN) begin
        word <= word >> CHUNKW;
        acc <= acc_n;
        idx <= idx + CW'(1);
        if (last) begin
          bus.rsp_id <= id;
          bus.rsp_residue <= acc_n;
          bus.rsp_div <= acc_n == 2'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_div3_rr_sched.sv
// tb_div3_rr_sched: directed and randomized checks against a word%3 / round-robin reference
module tb_div3_rr_sched;
  localparam int NREQ = 4;
  localparam int WORDW = 64;
  localparam int CHUNKW = 16;
  localparam int NCHUNK = WORDW / CHUNKW;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  div3_rr_sched_if #(.NREQ(NREQ), .WORDW(WORDW)) bus ();
  div3_rr_sched #(.NREQ(NREQ), .WORDW(WORDW), .CHUNKW(CHUNKW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0, passed = 0;
  int ptr_m = NREQ - 1;
  bit busy = 0, hs = 0;
  int age = 0, exp_id = 0, exp_res = 0, hs_id = 0;
  int accepted = 0, responded = 0;
  int last_id, last_res, last_div, last_age;
  int grants[$];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic set_req(int i, bit v, logic [63:0] d);
    bus.req_valid[i] = v;
    bus.req_data[i*WORDW +: WORDW] = d;
  endtask
  function automatic logic [63:0] rnd_word();
    int k = $urandom_range(0, 7);
    return k == 0 ? 64'd0 : k == 1 ? '1 : {$urandom, $urandom};
  endfunction
  // one clock: check outputs against the model, then advance the model across the edge
  task automatic step();
    int w;
    logic [NREQ-1:0] er;
    bit erv;
    logic [63:0] wd;
    #1;
    w = -1;
    for (int i = 1; i <= NREQ; i++)
      if (w < 0 && bus.req_valid[(ptr_m + i) % NREQ]) w = (ptr_m + i) % NREQ;
    er = '0;
    if (!rst && !busy && w >= 0) er[w] = 1'b1;
    erv = busy && age >= NCHUNK + 1;
    chk("req_ready", bus.req_ready, er);
    chk("ready_onehot", $countones(bus.req_ready) <= 1, 1);
    chk("rsp_valid", bus.rsp_valid, erv);
    if (erv) begin
      chk("rsp_id", bus.rsp_id, exp_id);
      chk("rsp_residue", bus.rsp_residue, exp_res);
      chk("rsp_div", bus.rsp_div, exp_res == 0);
    end
    hs = 0;
    if (rst) begin
      busy = 0;
      ptr_m = NREQ - 1;
      age = 0;
    end else if (erv && bus.rsp_ready) begin
      busy = 0;
      responded++;
      last_id = bus.rsp_id;
      last_res = bus.rsp_residue;
      last_div = bus.rsp_div;
      last_age = age;
    end else if (er != 0) begin
      wd = bus.req_data[w*WORDW +: WORDW];
      busy = 1;
      age = 0;
      exp_id = w;
      exp_res = int'(wd % 64'd3);
      ptr_m = w;
      accepted++;
      hs = 1;
      hs_id = w;
      grants.push_back(w);
    end
    if (busy) age++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = 'x;
    bus.rsp_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout", busy, 0);
  endtask
  task automatic run_word(logic [63:0] d, int exp_r);
    int r0 = responded, n = 0;
    set_req(0, 1, d);
    while (responded == r0 && n < 40) begin
      step();
      if (hs) set_req(0, 0, 'x);
      n++;
    end
    chk("word_timeout", responded, r0 + 1);
    chk("word_id", last_id, 0);
    chk("word_residue", last_res, exp_r);
    chk("word_div", last_div, exp_r == 0);
    chk("word_latency", last_age, NCHUNK + 1);
  endtask
  initial begin
    int n, a0, r0;
    int exp3[6] = '{0, 1, 2, 3, 0, 1};
    int exp4[4] = '{3, 1, 3, 1};
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = 'x;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_div", bus.rsp_div, 0);
    chk("rst_rsp_residue", bus.rsp_residue, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    run_word(64'd0, 0);
    run_word(64'd7, 1);
    run_word(64'd5, 2);
    run_word(64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_word(64'h0000_0001_0000_0000, 1);
    // all four requesters continuously valid
    do_reset();
    grants.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 64'd100 + 64'(i));
    n = 0;
    while (grants.size() < 6 && n < 200) begin
      step();
      if (hs) set_req(hs_id, 1, {$urandom, $urandom});
      n++;
    end
    chk("rr4_timeout", grants.size(), 6);
    for (int k = 0; k < 6 && k < grants.size(); k++) chk("rr4_order", grants[k], exp3[k]);
    // only requesters 1 and 3
    set_req(0, 0, 'x);
    set_req(2, 0, 'x);
    set_req(1, 1, 64'd12345);
    grants.delete();
    n = 0;
    while (grants.size() < 4 && n < 200) begin
      step();
      if (hs) set_req(hs_id, 1, {$urandom, $urandom});
      n++;
    end
    chk("rr2_timeout", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("rr2_order", grants[k], exp4[k]);
    // consumer back-pressure in RESP
    drain();
    set_req(2, 1, 64'd1000);
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!(busy && age >= NCHUNK + 1) && n < 40) begin
      step();
      if (hs) set_req(2, 0, 'x);
      n++;
    end
    chk("bp_timeout", busy && age >= NCHUNK + 1, 1);
    set_req(1, 1, 64'd77);
    repeat (6) step();
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_age", last_age, NCHUNK + 7);
    chk("bp_id", last_id, 2);
    chk("bp_residue", last_res, 1);
    // reset while word 9 is mid-RUN
    drain();
    set_req(3, 1, 64'd9);
    n = 0;
    while (!busy && n < 40) begin
      step();
      n++;
    end
    set_req(3, 0, 'x);
    while (busy && age < 3 && n < 80) begin
      step();
      n++;
    end
    r0 = responded;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rsp_id", bus.rsp_id, 0);
    chk("mid_rsp_div", bus.rsp_div, 0);
    chk("mid_rsp_residue", bus.rsp_residue, 0);
    set_req(0, 1, 64'd12);
    set_req(2, 1, 64'd13);
    n = 0;
    while (!hs && n < 40) begin
      step();
      n++;
    end
    chk("mid_next_grant", hs_id, 0);
    chk("mid_no_rsp", responded, r0);
    drain();
    chk("mid_one_rsp", responded, r0 + 1);
    // randomized traffic
    a0 = accepted;
    r0 = responded;
    n = 0;
    while (accepted - a0 < 1000 && n < 60000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !(hs && hs_id == i)) begin
          if ($urandom_range(0, 7) == 0) set_req(i, 0, 'x);
        end else if ($urandom_range(0, 2) != 0) set_req(i, 1, rnd_word());
        else set_req(i, 0, 'x);
      end
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      step();
      n++;
    end
    chk("rand_words", accepted - a0, 1000);
    drain();
    chk("rand_no_loss", responded - r0, accepted - a0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/div3_rr_sched.md
Name: div3_rr_sched

Overview:
Shared divisibility-by-3 engine with a round-robin front end. Up to NREQ requesters submit WORDW-bit words over valid/ready. The block grants one requester, walks the word CHUNKW bits per cycle through a single mod-3 residue datapath, and returns the divisible flag, the residue and the requester id over a valid/ready response port. It sits between multiple number producers and one div-3 unit that is too costly to replicate.

Parameters:
NREQ, 4, number of requesters (2..8)
WORDW, 64, request word width; must be a multiple of CHUNKW
CHUNKW, 16, bits processed per cycle; must be even so 2^CHUNKW ≡ 1 (mod 3)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester word valid
req_data  in  NREQ*WORDW  packed words; requester i at [i*WORDW +: WORDW]
req_ready  out  NREQ  one-hot grant/accept; at most one bit high
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  clog2(NREQ)  index of requester whose word produced the result
rsp_div  out  1  1 iff word mod 3 == 0
rsp_residue  out  2  word mod 3, range 0..2

Behaviour:
- NCHUNK = WORDW/CHUNKW. Chunk k = word[k*CHUNKW +: CHUNKW], processed LSB chunk first.
- Chunk residue = (sum of even-index bits − sum of odd-index bits) mod 3, reduced into 0..2. Bias to a non-negative value before the mod, with no signed underflow.
- Accumulator: acc <= (acc + chunk_res) mod 3. acc stays 2 bits and never holds 3.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - req_ready is driven combinationally: one-hot on the round-robin winner among the set req_valid bits, all zero if none are set.
  - On a handshake, capture the word, the id and the pointer = id. Clear acc and chunk index, then go to RUN.
- Round robin: the search starts at (ptr+1) mod NREQ and wraps. Reset ptr = NREQ-1, so requester 0 wins first.
- RUN:
  - One chunk per cycle. After chunk NCHUNK-1 is folded in, go to RESP.
  - req_ready is all zero throughout RUN.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_div and rsp_residue come from registers and are stable while rsp_valid && !rsp_ready.
  - rsp_div = (rsp_residue == 0).
  - On rsp_ready, go to IDLE with rsp_valid = 0 on the next cycle. No request is accepted in the same cycle as the response is accepted.
- Latency: accept on edge T, then rsp_valid rises after edge T+NCHUNK, i.e. NCHUNK+1 edges. Minimum issue interval is NCHUNK+2 cycles per word.
- Requester rule: req_data must hold while req_valid && !req_ready. A requester may drop req_valid before grant; the arbiter reevaluates every IDLE cycle.
- Reset values: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_div = 0, rsp_residue = 0, state = IDLE, ptr = NREQ-1, acc = 0.
- Reset mid-RUN or mid-RESP: the in-flight word and result are discarded, no response is issued, and all outputs take reset values on the next cycle.
- Simultaneous rst and handshake: rst wins.
- req_valid changes during RUN/RESP are ignored until IDLE.
- X on unselected req_data must not propagate to outputs.

Test Plan:
- Single requester 0 with these words, rsp_ready held 1 -> each rsp_valid exactly 5 cycles after accept, rsp_id = 0:
  - 64'd0 -> div = 1, residue = 0
  - 64'd7 -> div = 0, residue = 1
  - 64'd5 -> residue = 2
  - 64'hFFFF_FFFF_FFFF_FFFF -> div = 1, residue = 0
  - 64'h0000_0001_0000_0000 -> residue = 1
- All 4 requesters continuously valid with distinct words -> grant order 0,1,2,3,0,1. rsp_id follows the same order, and each result matches that requester's word.
- Only requesters 1 and 3 valid after a grant to 3 -> next grants 1,3,1. Requesters 0 and 2 are never granted.
- rsp_ready held 0 for 6 cycles in RESP -> rsp_valid, rsp_id and result unchanged, req_ready all 0. Then rsp_ready = 1 -> IDLE, and the next grant is no earlier than the following cycle.
- rst pulsed during RUN chunk 2 of word 64'd9 -> no response for that word. Outputs take reset values the next cycle, and the next grant goes to requester 0 if valid.
- Randomized: 1000 words with random valid, rsp_ready and data -> compare against a reference model of word % 3 and round-robin order. Check no lost or duplicated responses and at most one req_ready bit high.
